id_ex_stage: RTL
================

ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameter width_B, default 32, data/PC width in bits.
REQ-002 Parameter Addr_B, default 5, register-address width in bits.
REQ-003 Parameter CTRL_W, default 8, control-bundle width in bits.
REQ-004 The block SHALL have one clock and a synchronous, active-high reset: clk (input, 1, rising-edge clock) and rst (input, 1, synchronous active-high reset).
REQ-005 Inputs from the ID stage:
- id_valid (1): ID holds a valid instruction.
- id_pc (width_B): instruction PC.
- id_rs, id_rt, id_rd (Addr_B each): register specifiers.
- id_rd1, id_rd2 (width_B): register-file read data for rs and rt.
- id_imm (width_B): sign-extended immediate.
- id_ctrl (CTRL_W): control bundle. Bit 0 is RegWrite, bit 1 is MemRead.
REQ-006 Inputs flush (1), a branch-taken squash from EX, and wb_we (1), wb_addr (Addr_B), wb_data (width_B), the write-back port driving the register file.
REQ-007 Outputs ex_valid (1), ex_pc, ex_a, ex_b, ex_imm (width_B), ex_rs, ex_rt, ex_rd (Addr_B), ex_ctrl (CTRL_W): the registered ID/EX contents.
REQ-008 Output stall_out (1), combinational: holds the PC and IF/ID upstream.
REQ-009 Output stall_cnt (16), registered: debug count of stall cycles.

Function
REQ-010 The block SHALL compute hazard = id_valid & ex_valid & ex_ctrl[1] & (ex_rt != 0) & (ex_rt == id_rs | ex_rt == id_rt).
REQ-011 stall_out SHALL equal hazard & ~flush.
REQ-012 Register update at each rising edge, in priority order:
- rst
- flush: insert bubble.
- stall_out: insert bubble.
- otherwise: load all ex_* from id_*, with ex_valid <= id_valid.
REQ-013 A bubble SHALL set ex_valid=0 and ex_ctrl=0; the other ex_* fields are don't-care, and the implementation holds them.
REQ-014 Latency SHALL be exactly one cycle from id_* to ex_*.
REQ-015 With flush and hazard asserted together, flush SHALL win: bubble inserted, stall_out=0.
REQ-016 A load-use hazard SHALL stall for exactly one cycle, because the next cycle's ex_ctrl[1]=0.
REQ-017 stall_cnt SHALL increment on each cycle with stall_out=1 and saturate at 16'hFFFF without wrapping.
REQ-018 stall_cnt SHALL be cleared only by rst.
REQ-019 Register 0 SHALL never match for hazard or bypass purposes.

Reset
REQ-020 When rst=1 at a clock edge, the block SHALL set all ex_* outputs to 0 and stall_cnt to 0.
REQ-021 rst SHALL override flush and stall in the same cycle.
REQ-022 After reset, ex_valid=0 means stall_out=0 until a valid load reaches EX.
REQ-023 Reset asserted mid-stall SHALL drop stall_out on the next cycle.

Configuration
REQ-024 The macro ID_WB_BYPASS_EN SHALL control the write-back bypass.
- Defined: when wb_we=1, wb_addr!=0 and wb_addr==id_rs, ex_a SHALL load wb_data instead of id_rd1. The same rule SHALL apply to id_rt and ex_b. This covers a same-cycle register-file write, which otherwise returns stale data.
- Undefined: ex_a and ex_b SHALL load id_rd1 and id_rd2 unconditionally, and the wb_* inputs are unused.

Structure
REQ-025 The shared package pipeline_pkg SHALL hold the CTRL bit indices (CTRL_REGWRITE=0, CTRL_MEMREAD=1, remaining bits reserved), the default widths, and STALL_CNT_W=16.
REQ-026 The hazard logic of REQ-010 and REQ-011 SHALL be a combinational sub-module, hazard_detect, instantiated once.

Verification
REQ-027 Reset: rst=1 for 2 cycles with random id_* -> all ex_*=0, stall_out=0, stall_cnt=0.
REQ-028 Pass-through: id_valid=1, id_pc=32'h0040_0010, id_rd1=32'h1234_5678 -> next cycle ex_pc=32'h0040_0010, ex_a=32'h1234_5678, ex_valid=1.
REQ-029 Load-use: EX holds ex_ctrl=8'h02 (MemRead) with ex_rt=5, ex_valid=1, and ID presents id_rs=5 ->
- stall_out=1 for one cycle;
- next cycle ex_valid=0, ex_ctrl=0;
- stall_cnt=1;
- the following cycle the ID instruction loads.
REQ-030 Flush during hazard: the scenario of REQ-029 plus flush=1 -> stall_out=0, bubble inserted, stall_cnt unchanged.
REQ-031 Bypass, with ID_WB_BYPASS_EN defined: wb_we=1, wb_addr=7, wb_data=32'hDEAD_BEEF, id_rs=7, id_rd1=32'h0 -> ex_a=32'hDEAD_BEEF. With wb_addr=0 instead -> ex_a=32'h0.
REQ-032 Saturation: force 70000 consecutive stall cycles -> stall_cnt reaches 16'hFFFF and holds there.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: control-bundle bit positions, default widths,
// debug counter width and small helpers used across pipeline stages.
// No logic, no latency, no backpressure of its own.
package pipeline_pkg;

  // Default datapath geometry
  localparam int WIDTH_B_DEF = 32;   // data / PC width
  localparam int ADDR_B_DEF  = 5;    // register specifier width
  localparam int CTRL_W_DEF  = 8;    // control bundle width

  // Control bundle bit positions; bits above CTRL_MEMREAD are reserved
  localparam int CTRL_REGWRITE = 0;
  localparam int CTRL_MEMREAD  = 1;

  // Width of the debug stall counter
  localparam int STALL_CNT_W = 16;

  // What the ID/EX register does at the next rising edge
  typedef enum logic [1:0] {
    UPD_LOAD   = 2'd0,  // capture the ID stage
    UPD_BUBBLE = 2'd1,  // kill the EX slot, keep datapath fields
    UPD_RESET  = 2'd2   // clear everything
  } upd_e;

  // Saturating increment for the stall counter
  function automatic logic [STALL_CNT_W-1:0] sat_inc(input logic [STALL_CNT_W-1:0] v);
    logic [STALL_CNT_W-1:0] r;
    r = v;
    if (v != {STALL_CNT_W{1'b1}}) begin
      r = v + 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use hazard detector between the ID instruction and the load in EX.
// Latency: purely combinational, zero cycles.
// Backpressure: stall_out holds PC and IF/ID; a flush suppresses it.
//
// Ports:
//   id_valid, id_rs, id_rt      : instruction currently in ID
//   ex_valid, ex_rt, ex_ctrl    : instruction currently in EX
//   flush                       : branch squash, wins over the stall
//   stall_out                   : hold upstream this cycle
module hazard_detect
  import pipeline_pkg::*;
#(
  parameter int Addr_B = ADDR_B_DEF,
  parameter int CTRL_W = CTRL_W_DEF
) (
  input  logic              id_valid,
  input  logic [Addr_B-1:0] id_rs,
  input  logic [Addr_B-1:0] id_rt,
  input  logic              ex_valid,
  input  logic [Addr_B-1:0] ex_rt,
  input  logic [CTRL_W-1:0] ex_ctrl,
  input  logic              flush,
  output logic              stall_out
);

  logic ex_is_load;
  logic rt_nonzero;
  logic src_match;
  logic hazard;

  assign ex_is_load = ex_valid & ex_ctrl[CTRL_MEMREAD];
  // r0 is hardwired to zero, so a load targeting it never creates a dependency
  assign rt_nonzero = (ex_rt != '0);
  assign src_match  = (ex_rt == id_rs) | (ex_rt == id_rt);

  assign hazard    = id_valid & ex_is_load & rt_nonzero & src_match;
  // A squashed ID instruction must not freeze the front end
  assign stall_out = hazard & ~flush;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall and optional write-back bypass.
// Latency: one cycle from id_* to ex_*.
// Backpressure: stall_out (combinational) holds PC and IF/ID; EX gets a bubble.
//
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   id_*                  : decoded instruction from ID
//   flush                 : branch-taken squash from EX
//   wb_we/wb_addr/wb_data : register-file write port (bypassed when
//                           ID_WB_BYPASS_EN is defined, otherwise unused)
//   ex_*                  : registered ID/EX contents
//   stall_out             : load-use stall request
//   stall_cnt             : saturating count of stall cycles (debug)
//
// Build option: define ID_WB_BYPASS_EN to forward a same-cycle write-back
// into ex_a / ex_b.
module id_ex_stage
  import pipeline_pkg::*;
#(
  parameter int width_B = WIDTH_B_DEF,
  parameter int Addr_B  = ADDR_B_DEF,
  parameter int CTRL_W  = CTRL_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  // ID stage
  input  logic                   id_valid,
  input  logic [width_B-1:0]     id_pc,
  input  logic [Addr_B-1:0]      id_rs,
  input  logic [Addr_B-1:0]      id_rt,
  input  logic [Addr_B-1:0]      id_rd,
  input  logic [width_B-1:0]     id_rd1,
  input  logic [width_B-1:0]     id_rd2,
  input  logic [width_B-1:0]     id_imm,
  input  logic [CTRL_W-1:0]      id_ctrl,
  // squash and write-back
  input  logic                   flush,
  input  logic                   wb_we,
  input  logic [Addr_B-1:0]      wb_addr,
  input  logic [width_B-1:0]     wb_data,
  // EX stage
  output logic                   ex_valid,
  output logic [width_B-1:0]     ex_pc,
  output logic [width_B-1:0]     ex_a,
  output logic [width_B-1:0]     ex_b,
  output logic [width_B-1:0]     ex_imm,
  output logic [Addr_B-1:0]      ex_rs,
  output logic [Addr_B-1:0]      ex_rt,
  output logic [Addr_B-1:0]      ex_rd,
  output logic [CTRL_W-1:0]      ex_ctrl,
  // stall
  output logic                   stall_out,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  upd_e                   upd;
  logic [width_B-1:0]     opa;
  logic [width_B-1:0]     opb;
  logic [STALL_CNT_W-1:0] stall_cnt_q;

  hazard_detect #(
    .Addr_B (Addr_B),
    .CTRL_W (CTRL_W)
  ) u_hazard (
    .id_valid  (id_valid),
    .id_rs     (id_rs),
    .id_rt     (id_rt),
    .ex_valid  (ex_valid),
    .ex_rt     (ex_rt),
    .ex_ctrl   (ex_ctrl),
    .flush     (flush),
    .stall_out (stall_out)
  );

  // Operand selection
`ifdef ID_WB_BYPASS_EN
  // The register file reads before it writes, so a write landing this cycle
  // would otherwise hand EX the stale value.
  always_comb begin
    opa = id_rd1;
    opb = id_rd2;
    if (wb_we && (wb_addr != '0) && (wb_addr == id_rs)) begin
      opa = wb_data;
    end
    if (wb_we && (wb_addr != '0) && (wb_addr == id_rt)) begin
      opb = wb_data;
    end
  end
`else
  assign opa = id_rd1;
  assign opb = id_rd2;

  logic wb_unused;
  assign wb_unused = ^{wb_we, wb_addr, wb_data};
`endif

  // Update priority: reset, then flush or stall (both bubble), then load
  always_comb begin
    upd = UPD_LOAD;
    if (rst) begin
      upd = UPD_RESET;
    end else if (flush || stall_out) begin
      upd = UPD_BUBBLE;
    end
  end

  always_ff @(posedge clk) begin
    case (upd)
      UPD_RESET: begin
        ex_valid <= 1'b0;
        ex_pc    <= '0;
        ex_a     <= '0;
        ex_b     <= '0;
        ex_imm   <= '0;
        ex_rs    <= '0;
        ex_rt    <= '0;
        ex_rd    <= '0;
        ex_ctrl  <= '0;
      end
      UPD_BUBBLE: begin
        // Only validity and control are killed; the datapath fields are
        // held, which saves enables on the wide registers.
        ex_valid <= 1'b0;
        ex_ctrl  <= '0;
      end
      default: begin
        ex_valid <= id_valid;
        ex_pc    <= id_pc;
        ex_a     <= opa;
        ex_b     <= opb;
        ex_imm   <= id_imm;
        ex_rs    <= id_rs;
        ex_rt    <= id_rt;
        ex_rd    <= id_rd;
        ex_ctrl  <= id_ctrl;
      end
    endcase
  end

  // Stall counter: cleared only by reset, saturates instead of wrapping
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if (stall_out) begin
      stall_cnt_q <= sat_inc(stall_cnt_q);
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule
